// File: rtl/m_demux_pkg.sv
// Shared slot-state encoding and select-width helper for the demux router.
package m_demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m_demux_slot.sv
// One-entry output slot: registered word + valid, 1-cycle load-to-valid latency.
// Reloads in the same cycle it drains, so a held ready gives one word per cycle.
module m_demux_slot
    import m_demux_pkg::*;
#(
    parameter int WORD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [WORD-1:0] load_data,
    input  logic            ready,
    output logic            valid,
    output logic [WORD-1:0] data,
    output logic            can_load
);

    slot_state_t state;
    slot_state_t state_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (load) state_next = FULL;
            FULL:  if (ready && !load) state_next = EMPTY;
        endcase
    end

    // Data only moves on load, so it holds steady while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    assign valid    = (state == FULL);
    assign can_load = (state == EMPTY) || ready;

endmodule

// File: rtl/m_demux_router.sv
// Routes each input word to one slot (or all slots on broadcast), 1-cycle latency;
// in_ready follows the target slot(s); out-of-range selects are dropped and counted.
module m_demux_router
    import m_demux_pkg::*;
#(
    parameter int WORD  = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = sel_width(N_OUT),
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD-1:0]       in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    output logic [N_OUT-1:0]      out_valid,
    input  logic [N_OUT-1:0]      out_ready,
    output logic [N_OUT*WORD-1:0] out_data,
    output logic                  drop_pulse,
    output logic [CNT_W-1:0]      drop_cnt
);

    logic [N_OUT-1:0] can_load;
    logic [N_OUT-1:0] load;
    logic             accept;
    logic             drop;
    logic             sel_ok;
    logic             uc_ok;
    int               sel_idx;

    always_comb begin
        sel_idx = int'(in_sel);
        sel_ok  = (sel_idx < N_OUT);
        uc_ok   = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (sel_idx == k) uc_ok = can_load[k];
        end

        if (!rst_n)        in_ready = 1'b0;
        else if (in_bcast) in_ready = &can_load;
        else if (!sel_ok)  in_ready = 1'b1;
        else               in_ready = uc_ok;

        accept = in_valid && in_ready;
        drop   = accept && !in_bcast && !sel_ok;
        load   = '0;
        for (int k = 0; k < N_OUT; k++) begin
            load[k] = accept && (in_bcast || sel_idx == k);
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        m_demux_slot #(.WORD(WORD)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*WORD +: WORD]),
            .can_load  (can_load[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_m_demux_router.sv
module tb_m_demux_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        drop_pulse;
    logic [7:0]  drop_cnt;

    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  in_data3;
    logic [1:0]  in_sel3;
    logic        in_bcast3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] out_data3;
    logic        drop_pulse3;
    logic [1:0]  drop_cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_demux_router dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    m_demux_router #(.WORD(8), .N_OUT(3), .SEL_W(2), .CNT_W(2)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .in_data    (in_data3),
        .in_sel     (in_sel3),
        .in_bcast   (in_bcast3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready3),
        .out_data   (out_data3),
        .drop_pulse (drop_pulse3),
        .drop_cnt   (drop_cnt3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s, input logic b);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        in_bcast = b;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 4'b1111;
        out_ready3 = 3'b111;
        drive(1'b1, 8'hEE, 2'd0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
            errors++; $display("FAIL reset_outputs got valid %b data %h exp 0 0", out_valid, out_data);
        end
        checks++;
        if (drop_pulse !== 1'b0 || drop_cnt !== 8'd0 || drop_cnt3 !== 2'd0) begin
            errors++; $display("FAIL reset_drop got %b %0d %0d exp 0 0 0", drop_pulse, drop_cnt, drop_cnt3);
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unicast();
        out_ready = 4'b1111;
        drive(1'b1, 8'hA5, 2'd2, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL uc_in_ready got %b exp 1", in_ready);
        end
        tick();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        checks++;
        if (out_valid !== 4'b0100 || out_data[23:16] !== 8'hA5) begin
            errors++; $display("FAIL uc_deliver got %b %h exp 0100 a5", out_valid, out_data[23:16]);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL uc_clear got %b exp 0000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        drive(1'b1, 8'h11, 2'd1, 1'b0);
        tick();
        drive(1'b1, 8'h22, 2'd1, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall_ready got %b exp 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h11) begin
            errors++; $display("FAIL bp_hold got %b %h exp 1 11", out_valid[1], out_data[15:8]);
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready);
        end
        tick();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        checks++;
        if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h22) begin
            errors++; $display("FAIL bp_no_bubble got %b %h exp 1 22", out_valid[1], out_data[15:8]);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL bp_drain got %b exp 0000", out_valid);
        end
    endtask

    task automatic test_broadcast();
        out_ready = 4'b1011;
        drive(1'b1, 8'h55, 2'd2, 1'b0);
        tick();
        drive(1'b1, 8'h3C, 2'd1, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bc_blocked_ready got %b exp 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h55) begin
            errors++; $display("FAIL bc_no_partial got %b %h exp 0100 55", out_valid, out_data[23:16]);
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bc_ready got %b exp 1", in_ready);
        end
        tick();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        checks++;
        if (out_valid !== 4'b1111 || out_data !== 32'h3C3C3C3C) begin
            errors++; $display("FAIL bc_deliver got %b %h exp 1111 3c3c3c3c", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL bc_clear got %b exp 0000", out_valid);
        end
    endtask

    task automatic test_invalid_sel();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        out_ready3 = 3'b111;
        in_valid3 = 1'b1;
        in_data3  = 8'hDD;
        in_sel3   = 2'd3;
        in_bcast3 = 1'b0;
        #1;
        checks++;
        if (in_ready3 !== 1'b1) begin
            errors++; $display("FAIL drop_in_ready got %b exp 1", in_ready3);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (drop_pulse3 !== 1'b1 || drop_cnt3 !== exp_cnt[i] || out_valid3 !== 3'b000) begin
                errors++;
                $display("FAIL drop_%0d got pulse %b cnt %0d valid %b exp 1 %0d 000",
                         i, drop_pulse3, drop_cnt3, out_valid3, exp_cnt[i]);
            end
        end
        in_sel3  = 2'd2;
        in_data3 = 8'h9A;
        tick();
        in_valid3 = 1'b0;
        checks++;
        if (drop_pulse3 !== 1'b0 || drop_cnt3 !== 2'd3 || out_valid3 !== 3'b100 || out_data3[23:16] !== 8'h9A) begin
            errors++;
            $display("FAIL drop_then_uc got pulse %b cnt %0d valid %b data %h exp 0 3 100 9a",
                     drop_pulse3, drop_cnt3, out_valid3, out_data3[23:16]);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        out_ready = 4'b0110;
        drive(1'b1, 8'h10, 2'd0, 1'b0);
        tick();
        drive(1'b1, 8'h13, 2'd3, 1'b0);
        tick();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        checks++;
        if (out_valid !== 4'b1001) begin
            errors++; $display("FAIL rm_setup got %b exp 1001", out_valid);
        end
        rst_n = 1'b0;
        drive(1'b1, 8'h44, 2'd1, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rm_in_ready got %b exp 0", in_ready);
        end
        tick();
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        checks++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0 || drop_cnt3 !== 2'd0) begin
            errors++; $display("FAIL rm_flush got %b %h %0d exp 0000 0 0", out_valid, out_data, drop_cnt3);
        end
        out_ready = 4'b1111;
        drive(1'b1, 8'h77, 2'd0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        checks++;
        if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h77) begin
            errors++; $display("FAIL rm_first got %b %h exp 0001 77", out_valid, out_data[7:0]);
        end
        tick();
    endtask

    task automatic test_streaming();
        logic [1:0] prev_sel;
        logic [7:0] prev_data;
        logic [1:0] s;
        logic [7:0] d;
        int stall_cnt = 0;
        int out_err = 0;
        out_ready = 4'b1111;
        prev_sel = 2'd0;
        prev_data = 8'h00;
        for (int i = 0; i <= 100; i++) begin
            if (i > 0) begin
                if (out_valid !== (4'b0001 << prev_sel) || out_data[prev_sel*8 +: 8] !== prev_data) begin
                    out_err++;
                    if (out_err == 1)
                        $display("FAIL stream_out at %0d got %b %h exp ch %0d %h",
                                 i, out_valid, out_data[prev_sel*8 +: 8], prev_sel, prev_data);
                end
            end
            if (i < 100) begin
                s = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                drive(1'b1, d, s, 1'b0);
                if (in_ready !== 1'b1) stall_cnt++;
                prev_sel = s;
                prev_data = d;
                tick();
            end
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        checks++;
        if (stall_cnt !== 0) begin
            errors++; $display("FAIL stream_throughput got %0d stalls exp 0", stall_cnt);
        end
        checks++;
        if (out_err !== 0) begin
            errors++; $display("FAIL stream_order got %0d bad cycles exp 0", out_err);
        end
    endtask

    initial begin
        in_valid3 = 1'b0;
        in_data3  = 8'h00;
        in_sel3   = 2'd0;
        in_bcast3 = 1'b0;
        out_ready3 = 3'b111;
        test_reset();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_invalid_sel();
        test_reset_midop();
        test_streaming();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
